// File: rtl/writeback_stage_if.sv
// Writeback stage bundle: execute-side request, interrupt/trap context inputs,
// and the register-file / CSR / trap / redirect outputs.
`default_nettype none

interface writeback_stage_if #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
);
  logic               e_valid;
  logic               e_stall;
  logic               e_clear;
  logic               e_wren;
  logic [4:0]         e_waddr;
  logic [XLEN-1:0]    e_wdata;
  logic               e_cwren;
  logic [11:0]        e_caddr;
  logic [XLEN-1:0]    e_cdata;
  logic [XLEN-1:0]    e_pc;
  logic [XLEN-1:0]    e_npc;
  logic               e_exception;
  logic [CAUSE_W-1:0] e_ecause;
  logic [XLEN-1:0]    e_etval;
  logic               e_mret;
  logic               e_wfi;
  logic               irq_pending;
  logic [CAUSE_W-1:0] irq_cause;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;

  logic               rf_wren;
  logic [4:0]         rf_waddr;
  logic [XLEN-1:0]    rf_wdata;
  logic               fwd_wren;
  logic [4:0]         fwd_waddr;
  logic [XLEN-1:0]    fwd_wdata;
  logic               csr_wren;
  logic [11:0]        csr_waddr;
  logic [XLEN-1:0]    csr_wdata;
  logic               trap_valid;
  logic [CAUSE_W-1:0] trap_cause;
  logic [XLEN-1:0]    trap_epc;
  logic [XLEN-1:0]    trap_tval;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               flush;
  logic               stall;
  logic [63:0]        instret;

  modport slave (
    input  e_valid, e_stall, e_clear, e_wren, e_waddr, e_wdata,
           e_cwren, e_caddr, e_cdata, e_pc, e_npc,
           e_exception, e_ecause, e_etval, e_mret, e_wfi,
           irq_pending, irq_cause, mtvec, mepc,
    output rf_wren, rf_waddr, rf_wdata, fwd_wren, fwd_waddr, fwd_wdata,
           csr_wren, csr_waddr, csr_wdata,
           trap_valid, trap_cause, trap_epc, trap_tval,
           redirect_valid, redirect_pc, flush, stall, instret
  );

  modport master (
    output e_valid, e_stall, e_clear, e_wren, e_waddr, e_wdata,
           e_cwren, e_caddr, e_cdata, e_pc, e_npc,
           e_exception, e_ecause, e_etval, e_mret, e_wfi,
           irq_pending, irq_cause, mtvec, mepc,
    input  rf_wren, rf_waddr, rf_wdata, fwd_wren, fwd_waddr, fwd_wdata,
           csr_wren, csr_waddr, csr_wdata,
           trap_valid, trap_cause, trap_epc, trap_tval,
           redirect_valid, redirect_pc, flush, stall, instret
  );
endinterface

`default_nettype wire

// File: rtl/writeback_stage.sv
// Writeback stage: registers the finalised execute result, drives RF/CSR
// writes, and owns trap sequencing, mret redirect, WFI sleep and instret.
`default_nettype none

module writeback_stage #(
  parameter int          XLEN        = 32,
  parameter int          CAUSE_W     = 5,
  parameter logic [63:0] INSTRET_RST = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave wb
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SLEEP = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [XLEN-1:0]    npc_q, npc_d;
  logic [63:0]        instret_q, instret_d;

  logic               rf_wren_q, rf_wren_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;
  logic               csr_wren_q, csr_wren_d;
  logic [11:0]        csr_waddr_q, csr_waddr_d;
  logic [XLEN-1:0]    csr_wdata_q, csr_wdata_d;
  logic               trap_valid_q, trap_valid_d;
  logic [CAUSE_W-1:0] trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]    trap_epc_q, trap_epc_d;
  logic [XLEN-1:0]    trap_tval_q, trap_tval_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
  logic               flush_q, flush_d;
  logic               stall_q, stall_d;

  logic               accept;

  // flush_q blocks the wrong-path instruction that arrives right behind a redirect
  assign accept = wb.e_valid & ~wb.e_stall & ~wb.e_clear & ~flush_q & (state_q == RUN);

  always_comb begin
    state_d          = state_q;
    npc_d            = npc_q;
    instret_d        = instret_q;
    rf_wren_d        = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    rf_wdata_d       = rf_wdata_q;
    csr_wren_d       = 1'b0;
    csr_waddr_d      = csr_waddr_q;
    csr_wdata_d      = csr_wdata_q;
    trap_valid_d     = 1'b0;
    trap_cause_d     = trap_cause_q;
    trap_epc_d       = trap_epc_q;
    trap_tval_d      = trap_tval_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;

    if (accept) begin
      if (wb.e_exception) begin
        trap_valid_d     = 1'b1;
        trap_cause_d     = wb.e_ecause;
        trap_epc_d       = wb.e_pc;
        trap_tval_d      = wb.e_etval;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = wb.mtvec;
        flush_d          = 1'b1;
      end else begin
        rf_wren_d   = wb.e_wren & (wb.e_waddr != 5'd0);
        rf_waddr_d  = wb.e_waddr;
        rf_wdata_d  = wb.e_wdata;
        csr_wren_d  = wb.e_cwren;
        csr_waddr_d = wb.e_caddr;
        csr_wdata_d = wb.e_cdata;
        instret_d   = instret_q + 64'd1;
        // An interrupt taken at this boundary resumes after the committed instruction
        if (wb.irq_pending) begin
          trap_valid_d     = 1'b1;
          trap_cause_d     = wb.irq_cause;
          trap_epc_d       = wb.e_npc;
          trap_tval_d      = '0;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = wb.mtvec;
          flush_d          = 1'b1;
        end else if (wb.e_mret) begin
          redirect_valid_d = 1'b1;
          redirect_pc_d    = wb.mepc;
          flush_d          = 1'b1;
        end else if (wb.e_wfi) begin
          npc_d   = wb.e_npc;
          state_d = SLEEP;
        end
      end
    end else if ((state_q == SLEEP) && wb.irq_pending) begin
      trap_valid_d     = 1'b1;
      trap_cause_d     = wb.irq_cause;
      trap_epc_d       = npc_q;
      trap_tval_d      = '0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = wb.mtvec;
      flush_d          = 1'b1;
      state_d          = RUN;
    end

    stall_d = (state_d == SLEEP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= RUN;
      npc_q            <= '0;
      instret_q        <= INSTRET_RST;
      rf_wren_q        <= 1'b0;
      rf_waddr_q       <= '0;
      rf_wdata_q       <= '0;
      csr_wren_q       <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      trap_valid_q     <= 1'b0;
      trap_cause_q     <= '0;
      trap_epc_q       <= '0;
      trap_tval_q      <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      npc_q            <= npc_d;
      instret_q        <= instret_d;
      rf_wren_q        <= rf_wren_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      csr_wren_q       <= csr_wren_d;
      csr_waddr_q      <= csr_waddr_d;
      csr_wdata_q      <= csr_wdata_d;
      trap_valid_q     <= trap_valid_d;
      trap_cause_q     <= trap_cause_d;
      trap_epc_q       <= trap_epc_d;
      trap_tval_q      <= trap_tval_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
    end
  end

  assign wb.rf_wren        = rf_wren_q;
  assign wb.rf_waddr       = rf_waddr_q;
  assign wb.rf_wdata       = rf_wdata_q;
  assign wb.fwd_wren       = rf_wren_q;
  assign wb.fwd_waddr      = rf_waddr_q;
  assign wb.fwd_wdata      = rf_wdata_q;
  assign wb.csr_wren       = csr_wren_q;
  assign wb.csr_waddr      = csr_waddr_q;
  assign wb.csr_wdata      = csr_wdata_q;
  assign wb.trap_valid     = trap_valid_q;
  assign wb.trap_cause     = trap_cause_q;
  assign wb.trap_epc       = trap_epc_q;
  assign wb.trap_tval      = trap_tval_q;
  assign wb.redirect_valid = redirect_valid_q;
  assign wb.redirect_pc    = redirect_pc_q;
  assign wb.flush          = flush_q;
  assign wb.stall          = stall_q;
  assign wb.instret        = instret_q;

endmodule

`default_nettype wire
